// File: rtl/intersection_phase_ctrl_if.sv
// intersection_phase_ctrl_if
// Bundles the tick/request inputs and the phase outputs of the intersection
// phase sequencer.
//   tick         one-cycle enable pulse from the seconds counter
//   car_ns       vehicle waiting on the north/south approach (level)
//   car_ew       vehicle waiting on the east/west approach (level)
//   req_ns_left  north/south left-turn request (pulse or level)
//   req_ew_left  east/west left-turn request (pulse or level)
//   phase        3-bit phase code for the light decoder
//   phase_start  high in the first cycle of each new phase
//   time_left    ticks remaining until the forced end of the current phase
// master drives the requests (top level / testbench), slave is the sequencer.
interface intersection_phase_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             tick;
    logic             car_ns;
    logic             car_ew;
    logic             req_ns_left;
    logic             req_ew_left;
    logic [2:0]       phase;
    logic             phase_start;
    logic [CNT_W-1:0] time_left;

    modport master (
        output tick, car_ns, car_ew, req_ns_left, req_ew_left,
        input  phase, phase_start, time_left
    );

    modport slave (
        input  tick, car_ns, car_ew, req_ns_left, req_ew_left,
        output phase, phase_start, time_left
    );
endinterface

// File: rtl/intersection_phase_ctrl.sv
// intersection_phase_ctrl
// Phase sequencer for the intersection lights. Walks NS green -> NS yellow ->
// all red -> (EW left) -> EW green -> EW yellow -> all red -> (NS left) -> ...
// advancing only on 1 Hz ticks. Greens are actuated: a waiting cross-road car
// or left request ends a green early once the minimum green has elapsed.
// Left-turn phases are inserted only when requested.
// Ports:
//   CLOCK_50  system clock, all state updates on the rising edge
//   resetn    asynchronous active-low reset
//   bus       intersection_phase_ctrl_if.slave (tick, car/req inputs,
//             phase, phase_start, time_left outputs)
module intersection_phase_ctrl #(
    parameter int T_GREEN_MIN = 5,
    parameter int T_GREEN_MAX = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_LEFT      = 4,
    parameter int CNT_W       = 5
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    intersection_phase_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        NS_ALLRED = 3'd2,
        EW_LEFT   = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        EW_ALLRED = 3'd6,
        NS_LEFT   = 3'd7
    } phase_t;

    localparam logic [CNT_W-1:0] GMIN   = CNT_W'(T_GREEN_MIN);
    localparam logic [CNT_W-1:0] GMAX   = CNT_W'(T_GREEN_MAX);
    localparam logic [CNT_W-1:0] YELLOW = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] ALLRED = CNT_W'(T_ALLRED);
    localparam logic [CNT_W-1:0] LEFT   = CNT_W'(T_LEFT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] gel_q, gel_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             pend_ns_q, pend_ns_d;
    logic             pend_ew_q, pend_ew_d;
    logic             start_q, start_d;

    logic [CNT_W-1:0] gel_inc;
    logic             is_green;
    logic             demand;
    logic             exit_now;
    phase_t           succ;

    // Length of a fixed phase; greens are timed by gel instead, so 0 there.
    function automatic logic [CNT_W-1:0] duration(input phase_t p);
        case (p)
            NS_YELLOW, EW_YELLOW: duration = YELLOW;
            NS_ALLRED, EW_ALLRED: duration = ALLRED;
            EW_LEFT, NS_LEFT:     duration = LEFT;
            default:              duration = '0;
        endcase
    endfunction

    // State register. Reset lands in NS green with gel=0, so the first tick
    // after release is tick 1 of NS green.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            phase_q   <= NS_GREEN;
            gel_q     <= '0;
            rem_q     <= '0;
            pend_ns_q <= 1'b0;
            pend_ew_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            gel_q     <= gel_d;
            rem_q     <= rem_d;
            pend_ns_q <= pend_ns_d;
            pend_ew_q <= pend_ew_d;
            start_q   <= start_d;
        end
    end

    // Next-state logic: successor selection, exit condition, timers and the
    // left-turn pending flags.
    always_comb begin
        phase_d   = phase_q;
        gel_d     = gel_q;
        rem_d     = rem_q;
        pend_ns_d = pend_ns_q;
        pend_ew_d = pend_ew_q;
        start_d   = 1'b0;
        gel_inc   = gel_q + ONE;
        is_green  = (phase_q == NS_GREEN) || (phase_q == EW_GREEN);
        demand    = 1'b0;
        succ      = NS_GREEN;

        case (phase_q)
            NS_GREEN: begin
                demand = bus.car_ew | pend_ew_q | bus.req_ew_left;
                succ   = NS_YELLOW;
            end
            NS_YELLOW: succ = NS_ALLRED;
            NS_ALLRED: succ = (pend_ew_q | bus.req_ew_left) ? EW_LEFT : EW_GREEN;
            EW_LEFT:   succ = EW_GREEN;
            EW_GREEN: begin
                demand = bus.car_ns | pend_ns_q | bus.req_ns_left;
                succ   = EW_YELLOW;
            end
            EW_YELLOW: succ = EW_ALLRED;
            EW_ALLRED: succ = (pend_ns_q | bus.req_ns_left) ? NS_LEFT : NS_GREEN;
            NS_LEFT:   succ = NS_GREEN;
            default:   succ = NS_GREEN;
        endcase

        exit_now = is_green ? (((gel_inc >= GMIN) && demand) || (gel_inc == GMAX))
                            : (rem_q == ONE);

        // A request is ignored while its own left phase is already running.
        if (bus.req_ns_left && (phase_q != NS_LEFT)) pend_ns_d = 1'b1;
        if (bus.req_ew_left && (phase_q != EW_LEFT)) pend_ew_d = 1'b1;

        if (bus.tick) begin
            if (exit_now) begin
                phase_d = succ;
                gel_d   = '0;
                rem_d   = duration(succ);
                start_d = 1'b1;
                // Entering a left phase serves the request, including one
                // arriving in this very cycle.
                if (succ == EW_LEFT) pend_ew_d = 1'b0;
                if (succ == NS_LEFT) pend_ns_d = 1'b0;
            end else if (is_green) begin
                gel_d = gel_inc;
            end else begin
                rem_d = rem_q - ONE;
            end
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_start = start_q;
    assign bus.time_left   = is_green ? (GMAX - gel_q) : rem_q;

endmodule
